// File: rtl/core_dispatcher_pkg.sv
// Shared types for the core dispatcher: per-core status codes and FSM states.
package core_dispatcher_pkg;

  // Two-bit command driven onto each processor's status input.
  typedef enum logic [1:0] {
    ST_HOLD  = 2'b00,
    ST_START = 2'b01,
    ST_RUN   = 2'b10,
    ST_ABORT = 2'b11
  } core_st_e;

  // Dispatcher job sequencing.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_ABORT  = 3'd3,
    S_DONE   = 3'd4
  } disp_state_e;

  localparam int NUM_CORES_DEF = 4;
  localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/core_dispatcher_if.sv
// Control/status bundle between the host, the processor array and the dispatcher.
interface core_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16
);
  logic                   start;
  logic [NUM_CORES-1:0]   core_mask;
  logic [CNT_W-1:0]       timeout_lim;
  logic [NUM_CORES-1:0]   end_process;
  logic [2*NUM_CORES-1:0] core_status;
  logic                   busy;
  logic                   done;
  logic                   timed_out;
  logic [NUM_CORES-1:0]   cores_done;
  logic [CNT_W-1:0]       run_cycles;

  // Host / processor side.
  modport master (
    output start, core_mask, timeout_lim, end_process,
    input  core_status, busy, done, timed_out, cores_done, run_cycles
  );

  // Dispatcher side.
  modport slave (
    input  start, core_mask, timeout_lim, end_process,
    output core_status, busy, done, timed_out, cores_done, run_cycles
  );
endinterface

// File: rtl/core_done_tracker.sv
// One core's sticky completion bit and the status code it is shown.
module core_done_tracker
  import core_dispatcher_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        capture,
  input  logic        mask_bit,
  input  logic        end_bit,
  input  disp_state_e state,
  output logic        new_done,
  output logic        done_bit,
  output logic [1:0]  status
);

  // A completion only counts for a launched core while the job is live.
  assign new_done = capture && mask_bit && end_bit;

  // Sticky done flag, cleared when a new job is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_bit <= 1'b0;
    end else if (clear) begin
      done_bit <= 1'b0;
    end else if (new_done) begin
      done_bit <= 1'b1;
    end
  end

  // Status decoded only from registered state, so no input reaches the core combinationally.
  always_comb begin
    status = ST_HOLD;
    case (state)
      S_LAUNCH: if (mask_bit)              status = ST_START;
      S_RUN:    if (mask_bit && !done_bit) status = ST_RUN;
      S_ABORT:  if (mask_bit && !done_bit) status = ST_ABORT;
      default:  status = ST_HOLD;
    endcase
  end

endmodule

// File: rtl/core_dispatcher.sv
// Launches a job on a subset of processor cores, tracks completion and enforces a cycle limit.
module core_dispatcher
  import core_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  core_dispatcher_if.slave  bus
);

  disp_state_e            state_reg, state_next;
  logic [NUM_CORES-1:0]   mask_reg;
  logic [CNT_W-1:0]       lim_reg;
  logic [CNT_W-1:0]       run_cycles_reg;
  logic                   timed_out_reg;
  logic [NUM_CORES-1:0]   new_done;
  logic [NUM_CORES-1:0]   cores_done;
  logic                   accept;
  logic                   capture;
  logic                   all_done;
  logic                   limit_hit;

  // A launch needs at least one core; an empty mask only produces a done pulse.
  assign accept    = (state_reg == S_IDLE) && bus.start && (bus.core_mask != '0);
  assign capture   = (state_reg == S_LAUNCH) || (state_reg == S_RUN);
  assign all_done  = ((cores_done | new_done) & mask_reg) == mask_reg;
  // Compared one bit wider so a saturated counter can never alias onto the limit.
  assign limit_hit = (lim_reg != '0) &&
                     (({1'b0, run_cycles_reg} + (CNT_W+1)'(1)) == {1'b0, lim_reg});

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    core_done_tracker u_trk (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .capture  (capture),
      .mask_bit (mask_reg[gi]),
      .end_bit  (bus.end_process[gi]),
      .state    (state_reg),
      .new_done (new_done[gi]),
      .done_bit (cores_done[gi]),
      .status   (bus.core_status[2*gi +: 2])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; completion is checked before the timeout so it wins a tie.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.start) state_next = (bus.core_mask != '0) ? S_LAUNCH : S_DONE;
      S_LAUNCH: state_next = S_RUN;
      S_RUN: begin
        if (all_done)       state_next = S_DONE;
        else if (limit_hit) state_next = S_ABORT;
      end
      S_ABORT:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Job parameters, run counter and timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg       <= '0;
      lim_reg        <= '0;
      run_cycles_reg <= '0;
      timed_out_reg  <= 1'b0;
    end else begin
      if (accept) begin
        mask_reg       <= bus.core_mask;
        lim_reg        <= bus.timeout_lim;
        run_cycles_reg <= '0;
      end else if (state_reg == S_RUN && run_cycles_reg != '1) begin
        run_cycles_reg <= run_cycles_reg + CNT_W'(1);
      end
      if (state_reg == S_IDLE && bus.start) begin
        timed_out_reg <= 1'b0;
      end else if (state_reg == S_RUN && state_next == S_ABORT) begin
        timed_out_reg <= 1'b1;
      end
    end
  end

  assign bus.busy       = (state_reg == S_LAUNCH) || (state_reg == S_RUN) || (state_reg == S_ABORT);
  assign bus.done       = (state_reg == S_DONE);
  assign bus.timed_out  = timed_out_reg;
  assign bus.cores_done = cores_done;
  assign bus.run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_core_dispatcher.sv
// Randomised self-checking bench: each job's expected waveform is derived from finish times.
module tb_core_dispatcher;
  import core_dispatcher_pkg::*;

  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   prev_to = 1'b0;

  core_dispatcher_if #(.NUM_CORES(4), .CNT_W(16)) bus ();

  core_dispatcher #(.NUM_CORES(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " idle done"}, 32'(bus.done), 32'd0);
    check_eq({tag, " idle status"}, 32'(bus.core_status), 32'd0);
    check_eq({tag, " idle timed_out"}, 32'(bus.timed_out), 32'(prev_to));
  endtask

  // Core i raises end_process at cycle fin[i] (cycle 0 = LAUNCH) and holds it.
  task automatic run_job(input logic [3:0] mask, input logic [15:0] lim,
                         input int f0, input int f1, input int f2, input int f3,
                         input logic [3:0] noise, input bit keep);
    int fin[4];
    int maxcap, c, t, e, d;
    bit to;
    logic [7:0] st;
    logic [3:0] cd, ep;
    fin = '{f0, f1, f2, f3};
    maxcap = 0;
    for (int i = 0; i < 4; i++) if (mask[i] && fin[i] > maxcap) maxcap = fin[i];
    c  = (maxcap < 1) ? 1 : maxcap;
    t  = (lim == 0) ? 1000000 : int'(lim);
    to = (t < c);
    e  = to ? t : c;
    d  = to ? e + 2 : e + 1;
    $display("job mask=%b lim=%0d fin=%0d,%0d,%0d,%0d expect_timeout=%0b run=%0d",
             mask, lim, f0, f1, f2, f3, to, e);
    @(negedge clk);
    check_idle("job");
    bus.start = 1'b1; bus.core_mask = mask; bus.timeout_lim = lim; bus.end_process = '0;
    @(posedge clk);
    for (int n = 0; n <= d; n++) begin
      @(negedge clk);
      st = '0; cd = '0;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (n == 0) st[2*i +: 2] = ST_START;
          else if (n <= e) begin
            st[2*i +: 2] = (fin[i] < n) ? ST_HOLD : ST_RUN;
            cd[i] = (fin[i] < n);
          end else begin
            if (to && n == e + 1) st[2*i +: 2] = (fin[i] <= e) ? ST_HOLD : ST_ABORT;
            cd[i] = (fin[i] <= e);
          end
        end
      end
      check_eq("core_status", 32'(bus.core_status), 32'(st));
      check_eq("cores_done", 32'(bus.cores_done), 32'(cd));
      check_eq("busy", 32'(bus.busy), 32'(n < d));
      check_eq("done", 32'(bus.done), 32'(n == d));
      check_eq("run_cycles", 32'(bus.run_cycles), (n == 0) ? 32'd0 : (n <= e) ? 32'(n - 1) : 32'(e));
      if (n <= e)      check_eq("timed_out run", 32'(bus.timed_out), 32'd0);
      else if (n == d) check_eq("timed_out done", 32'(bus.timed_out), 32'(to));
      ep = '0;
      for (int i = 0; i < 4; i++) if (mask[i] && fin[i] <= n) ep[i] = 1'b1;
      bus.end_process = ep | (noise & ~mask);
      bus.start = keep ? 1'b1 : (n < d) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (n < d) @(posedge clk);
    end
    bus.end_process = '0;
    prev_to = to;
  endtask

  task automatic run_empty();
    $display("job mask=0000 (no launch)");
    @(negedge clk);
    check_idle("empty");
    bus.start = 1'b1; bus.core_mask = '0; bus.timeout_lim = 16'd3;
    @(posedge clk);
    @(negedge clk);
    check_eq("empty done", 32'(bus.done), 32'd1);
    check_eq("empty busy", 32'(bus.busy), 32'd0);
    check_eq("empty status", 32'(bus.core_status), 32'd0);
    check_eq("empty timed_out", 32'(bus.timed_out), 32'd0);
    bus.start = 1'b0;
    prev_to = 1'b0;
    @(negedge clk);
    check_eq("empty done drop", 32'(bus.done), 32'd0);
    check_eq("empty status idle", 32'(bus.core_status), 32'd0);
  endtask

  task automatic reset_mid_run();
    $display("job mask=1111 reset mid-run");
    @(negedge clk);
    bus.start = 1'b1; bus.core_mask = 4'b1111; bus.timeout_lim = '0; bus.end_process = '0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("pre-reset status", 32'(bus.core_status), 32'haa);
    #1 rst = 1'b1;
    #1;
    check_eq("async rst status", 32'(bus.core_status), 32'd0);
    check_eq("async rst busy", 32'(bus.busy), 32'd0);
    check_eq("async rst run_cycles", 32'(bus.run_cycles), 32'd0);
    check_eq("async rst cores_done", 32'(bus.cores_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_to = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  m;
    logic [15:0] l;
    int          f[4];
    bus.start = 1'b0; bus.core_mask = '0; bus.timeout_lim = '0; bus.end_process = '0;
    repeat (2) @(negedge clk);
    check_eq("reset status", 32'(bus.core_status), 32'd0);
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset done", 32'(bus.done), 32'd0);
    check_eq("reset timed_out", 32'(bus.timed_out), 32'd0);
    check_eq("reset cores_done", 32'(bus.cores_done), 32'd0);
    check_eq("reset run_cycles", 32'(bus.run_cycles), 32'd0);
    rst = 1'b0;

    run_job(4'b0101, 16'd0, 5, NEVER, 9, NEVER, 4'b0000, 1'b0);
    run_job(4'b0011, 16'd8, 3, NEVER, NEVER, NEVER, 4'b0000, 1'b0);
    run_job(4'b0110, 16'd6, NEVER, 2, 6, NEVER, 4'b1001, 1'b0);
    run_job(4'b1001, 16'd0, 3, NEVER, NEVER, 4, 4'b0000, 1'b1);
    run_job(4'b1001, 16'd0, 0, NEVER, NEVER, 2, 4'b0000, 1'b0);
    run_empty();
    run_job(4'b0001, 16'd0, 6, NEVER, NEVER, NEVER, 4'b1000, 1'b0);
    run_job(4'b1111, 16'd1, 0, 0, 0, 0, 4'b0000, 1'b0);
    run_job(4'b0010, 16'd1, NEVER, NEVER, NEVER, NEVER, 4'b0000, 1'b0);
    reset_mid_run();

    for (int j = 0; j < 25; j++) begin
      m = 4'($urandom_range(1, 15));
      l = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      for (int i = 0; i < 4; i++)
        f[i] = (l != 0 && $urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 18));
      run_job(m, l, f[0], f[1], f[2], f[3], 4'($urandom), 1'b0);
    end

    @(negedge clk);
    check_idle("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
